// File: rtl/convolution_procesor_adder_arbiter.sv
// Shared signed adder with round-robin arbitration across NUM_REQ requesters.
// One result register sits at the output behind a valid/ready handshake;
// a new pair may be granted in the same cycle the held result is consumed.
// Build option: define CONVOLUTION_PROCESOR_ADDER_SAT_EN to saturate res_data
// on signed overflow instead of wrapping (res_ovf is reported either way).
module convolution_procesor_adder_arbiter #(
    parameter int DATA_WIDTH = 22,
    parameter int NUM_REQ    = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic [DATA_WIDTH-1:0]           res_data,
    output logic [$clog2(NUM_REQ)-1:0]      res_id,
    output logic                            res_ovf
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int ID_W1 = ID_W + 1;

    localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [ID_W-1:0]         id_q, id_d;
    logic                    ovf_q, ovf_d;

    logic                    grant_en;
    logic                    grant_any;
    logic [ID_W-1:0]         grant_idx;
    logic [ID_W:0]           cand;

    logic [DATA_WIDTH-1:0]   a_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0]   b_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0]   a_sel, b_sel;
    logic [DATA_WIDTH:0]     sum;
    logic                    sum_ovf;
    logic [DATA_WIDTH-1:0]   sum_data;

    // Unpack the flat operand buses into per-requester words.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[gi*DATA_WIDTH +: DATA_WIDTH];
            assign b_arr[gi] = req_b[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Grants are allowed only when the result slot is free or being drained;
    // reset blocks grants so nothing is accepted while the block is held.
    assign grant_en = rst_n && ((state_q == EMPTY) || res_ready);

    // Round-robin search starting at rr_ptr, wrapping at NUM_REQ-1.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + ID_W1'(k);
            if (cand >= ID_W1'(NUM_REQ)) begin
                cand = cand - ID_W1'(NUM_REQ);
            end
            if (!grant_any && grant_en && req_valid[cand[ID_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[ID_W-1:0];
            end
        end
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Sign-extended add of the granted pair, with overflow detection and
    // optional saturation toward the operands' common sign.
    always_comb begin
        a_sel   = a_arr[grant_idx];
        b_sel   = b_arr[grant_idx];
        sum     = {a_sel[DATA_WIDTH-1], a_sel} + {b_sel[DATA_WIDTH-1], b_sel};
        sum_ovf = sum[DATA_WIDTH] ^ sum[DATA_WIDTH-1];
`ifdef CONVOLUTION_PROCESOR_ADDER_SAT_EN
        if (sum_ovf) begin
            sum_data = sum[DATA_WIDTH] ? MIN_NEG : MAX_POS;
        end else begin
            sum_data = sum[DATA_WIDTH-1:0];
        end
`else
        sum_data = sum[DATA_WIDTH-1:0];
`endif
    end

    // Next-state for the output FSM, result register and round-robin pointer.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        data_d   = data_q;
        id_d     = id_q;
        ovf_d    = ovf_q;
        if (grant_any) begin
            state_d  = FULL;
            data_d   = sum_data;
            id_d     = grant_idx;
            ovf_d    = sum_ovf;
            rr_ptr_d = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
        end else if ((state_q == FULL) && res_ready) begin
            state_d = EMPTY;
        end
    end

    // State registers; reset discards any held result and rewinds the pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            rr_ptr_q <= '0;
            data_q   <= '0;
            id_q     <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            data_q   <= data_d;
            id_q     <= id_d;
            ovf_q    <= ovf_d;
        end
    end

    assign res_valid = (state_q == FULL);
    assign res_data  = data_q;
    assign res_id    = id_q;
    assign res_ovf   = ovf_q;

endmodule

// File: tb/tb_convolution_procesor_adder_arbiter.sv
// Directed bench for convolution_procesor_adder_arbiter at DATA_WIDTH=8,
// NUM_REQ=4. Expected values are hand-computed constants; the overflow
// expectations follow CONVOLUTION_PROCESOR_ADDER_SAT_EN when it is defined.
module tb_convolution_procesor_adder_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_a = '0;
    logic [NR*DW-1:0]  req_b = '0;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [DW-1:0]     res_data;
    logic [1:0]        res_id;
    logic              res_ovf;

    int pass_cnt = 0;
    int total_cnt = 0;

    convolution_procesor_adder_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ovf   (res_ovf)
    );

    always #5 clk = ~clk;

    // Single comparison point: count it, report a mismatch.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pair(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
    endtask

    logic [7:0] exp_wrap1;
    logic [7:0] exp_wrap2;
    logic [NR-1:0] exp_gnt;

    initial begin
`ifdef CONVOLUTION_PROCESOR_ADDER_SAT_EN
        exp_wrap1 = 8'h7F;
        exp_wrap2 = 8'h80;
`else
        exp_wrap1 = 8'hC8;
        exp_wrap2 = 8'h7F;
`endif
        // Reset state, with requests and consumer active to prove grants are blocked
        req_valid = 4'b1111;
        res_ready = 1'b1;
        #3;
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_res_valid", 32'(res_valid), 32'h0);
        check("rst_res_data",  32'(res_data),  32'h0);
        check("rst_res_id",    32'(res_id),    32'h0);
        check("rst_res_ovf",   32'(res_ovf),   32'h0);
        step();
        step();
        check("rst_hold_valid", 32'(res_valid), 32'h0);

        // Single request: 5 + (-3) = 2 from requester 0
        req_valid = 4'b0001;
        set_pair(0, 8'd5, 8'hFD);
        rst_n = 1'b1;
        #1;
        check("single_ready", 32'(req_ready), 32'h1);
        step();
        check("single_valid", 32'(res_valid), 32'h1);
        check("single_data",  32'(res_data),  32'h2);
        check("single_id",    32'(res_id),    32'h0);
        check("single_ovf",   32'(res_ovf),   32'h0);
        req_valid = 4'b0000;
        #1;
        check("drain_ready", 32'(req_ready), 32'h0);
        step();
        check("drain_empty", 32'(res_valid), 32'h0);

        // Reset pulse between edges so round-robin starts at 0
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;

        // Round-robin: requester i sums i*10 + 1
        for (int i = 0; i < NR; i++) set_pair(i, 8'(i*10), 8'd1);
        req_valid = 4'b1111;
        res_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            exp_gnt = 4'(1 << (c % 4));
            check($sformatf("rr_ready_%0d", c), 32'(req_ready), 32'(exp_gnt));
            step();
            check($sformatf("rr_valid_%0d", c), 32'(res_valid), 32'h1);
            check($sformatf("rr_id_%0d", c),    32'(res_id),    32'(c % 4));
            check($sformatf("rr_data_%0d", c),  32'(res_data),  32'((c % 4) * 10 + 1));
        end

        // Backpressure: result from requester 3 (31) held, no grants
        res_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("bp_ready_%0d", c), 32'(req_ready), 32'h0);
            check($sformatf("bp_data_%0d", c),  32'(res_data),  32'd31);
            check($sformatf("bp_id_%0d", c),    32'(res_id),    32'd3);
            check($sformatf("bp_valid_%0d", c), 32'(res_valid), 32'h1);
            step();
        end
        res_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(req_ready), 32'h1);
        step();
        check("bp_next_valid", 32'(res_valid), 32'h1);
        check("bp_next_id",    32'(res_id),    32'd0);
        check("bp_next_data",  32'(res_data),  32'd1);

        // Overflow: 100 + 100 (pointer at 1, wraps to requester 0)
        req_valid = 4'b0001;
        set_pair(0, 8'd100, 8'd100);
        #1;
        check("ovf1_ready", 32'(req_ready), 32'h1);
        step();
        check("ovf1_ovf",  32'(res_ovf),  32'h1);
        check("ovf1_data", 32'(res_data), 32'(exp_wrap1));
        // -128 + -1
        set_pair(0, 8'h80, 8'hFF);
        step();
        check("ovf2_ovf",  32'(res_ovf),  32'h1);
        check("ovf2_data", 32'(res_data), 32'(exp_wrap2));
        // -100 + -28 = -128 exactly, no overflow
        set_pair(0, 8'h9C, 8'hE4);
        step();
        check("edge_ovf",  32'(res_ovf),  32'h0);
        check("edge_data", 32'(res_data), 32'h80);

        // Reset mid-operation: grant requester 1 so rr_ptr=2 and state FULL
        req_valid = 4'b0010;
        set_pair(1, 8'd7, 8'd8);
        step();
        check("pre_rst_id",    32'(res_id),    32'd1);
        check("pre_rst_valid", 32'(res_valid), 32'h1);
        res_ready = 1'b0;
        req_valid = 4'b0110;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(res_valid), 32'h0);
        check("mid_rst_ready", 32'(req_ready), 32'h0);
        check("mid_rst_data",  32'(res_data),  32'h0);
        #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'h2);
        step();
        check("post_rst_id",    32'(res_id),    32'd1);
        check("post_rst_data",  32'(res_data),  32'd15);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/convolution_procesor_adder_arbiter.md
CONVOLUTION_PROCESOR_ADDER_ARBITER -- requirements
Module: convolution_procesor_adder_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 22: operand and result width, 2's complement.
REQ-002 The block SHALL have parameter NUM_REQ, default 4: number of requesters sharing the adder, range 2..8.
REQ-003 The block SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 The block SHALL have port req_valid, input, NUM_REQ: bit i high means requester i presents an operand pair.
REQ-006 The block SHALL have port req_ready, output, NUM_REQ: one-hot grant; bit i high means requester i's pair is accepted this cycle.
REQ-007 The block SHALL have port req_a, input, NUM_REQ*DATA_WIDTH: operand A; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 The block SHALL have port req_b, input, NUM_REQ*DATA_WIDTH: operand B, packed the same way as req_a.
REQ-009 The block SHALL have port res_valid, output, 1: result register holds an unconsumed sum.
REQ-010 The block SHALL have port res_ready, input, 1: the consumer accepts the result this cycle.
REQ-011 The block SHALL have port res_data, output, DATA_WIDTH: the sum.
REQ-012 The block SHALL have port res_id, output, $clog2(NUM_REQ): index of the requester that owns res_data.
REQ-013 The block SHALL have port res_ovf, output, 1: signed overflow occurred on res_data.

Function
REQ-014 Transfers SHALL follow valid/ready on both sides: a request transfers when req_valid[i] and req_ready[i] are both high; a result transfers when res_valid and res_ready are both high.
REQ-015 The output stage SHALL be a two-state FSM:
  - EMPTY: res_valid=0.
  - FULL: res_valid=1.
  - EMPTY->FULL on a grant.
  - FULL->EMPTY on a result transfer with no grant in the same cycle.
  - FULL stays FULL on a result transfer with a simultaneous grant.
REQ-016 A grant SHALL be possible only when (state EMPTY) or (state FULL and res_ready=1); otherwise req_ready SHALL be all zeros.
REQ-017 Arbitration SHALL be round-robin: search starts at pointer rr_ptr and wraps from NUM_REQ-1 to 0; the first requester with req_valid high is granted.
REQ-018 After a grant to index g, rr_ptr SHALL become (g+1) mod NUM_REQ; with no grant, rr_ptr SHALL hold.
REQ-019 req_ready SHALL be combinational from req_valid, rr_ptr, state and res_ready, and SHALL have at most one bit set.
REQ-020 Latency SHALL be one cycle: a pair granted in cycle N appears on res_data/res_id/res_ovf with res_valid=1 in cycle N+1.
REQ-021 The sum SHALL be computed as the sign-extended DATA_WIDTH+1-bit sum of A and B.
REQ-022 res_ovf SHALL be 1 when bit DATA_WIDTH of the sum differs from bit DATA_WIDTH-1.
REQ-023 res_data, res_id and res_ovf SHALL hold stable while res_valid=1 and res_ready=0.
REQ-024 With req_valid all zeros and a result transfer, the FSM SHALL go to EMPTY with no grant.

Reset
REQ-025 While rst_n=0 the block SHALL asynchronously force state=EMPTY, res_valid=0, res_data=0, res_id=0, res_ovf=0 and rr_ptr=0.
REQ-026 A result or grant in flight when rst_n falls SHALL be discarded; req_ready SHALL be all zeros while rst_n=0.
REQ-027 The first rising edge with rst_n=1 SHALL be able to grant.

Configuration
REQ-028 Macro CONVOLUTION_PROCESOR_ADDER_SAT_EN SHALL select the overflow behaviour of res_data:
  - Defined: on overflow, res_data saturates to the signed maximum (A,B positive) or signed minimum (A,B negative).
  - Undefined: res_data is the low DATA_WIDTH bits of the sum (wrap-around).
  - res_ovf is produced in both builds.

Verification
REQ-029 The bench SHALL cover these directed scenarios (DATA_WIDTH=8, NUM_REQ=4):
  - Single request: req0 A=5, B=-3, res_ready=1 -> req_ready=0001 in cycle N; res_valid=1, res_data=2, res_id=0, res_ovf=0 in N+1.
  - Round-robin: all four req_valid high, res_ready=1 for 8 cycles -> grant order 0,1,2,3,0,1,2,3, one grant per cycle, res_id follows one cycle later.
  - Backpressure: state FULL with res_ready=0 for 3 cycles -> req_ready=0000 and res_data stable; res_ready=1 -> grant and consume in the same cycle, next result on the following cycle.
  - Overflow: A=100, B=100 -> res_ovf=1; res_data=-56 without the macro, 127 with the macro. A=-128, B=-1 -> res_data=127 without the macro, -128 with the macro.
  - Reset mid-operation: rst_n low while FULL with rr_ptr=2 -> res_valid=0 immediately; after release, the first grant goes to the lowest valid index starting from 0.
